// File: rtl/frisc_muldiv_pkg.sv
// frisc_pkg: shared types and helpers for the frisc RV32M multiply/divide unit.
//   muldiv_op_e    : RV32M funct3 encodings of the eight M-extension ops.
//   muldiv_state_e : sequencer states of the iterative unit.
//   is_div / is_rem / a_signed / b_signed : op classification helpers.
package frisc_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    // True for every divider-class op (quotient or remainder).
    function automatic logic is_div(input muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(input muldiv_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic a_signed(input muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic b_signed(input muldiv_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/frisc_muldiv_if.sv
// frisc_muldiv_if: request/response handshake bundle of the multiply/divide unit.
//   req_valid/req_ready/req_op/req_a/req_b : operation request (valid/ready).
//   resp_valid/resp_ready/resp_data        : result response (valid/ready).
//   master : issue/consumer side.   slave : the unit itself.
interface frisc_muldiv_if #(
    parameter int WIDTH = 32
);
    import frisc_pkg::*;

    logic             req_valid;
    logic             req_ready;
    muldiv_op_e       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_data;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data
    );

endinterface

// File: rtl/frisc_muldiv_step.sv
// frisc_muldiv_step: one combinational iteration of the multiply/divide unit.
//   i_div     : 1 = restoring-divide step, 0 = shift-add multiply step.
//   i_acc     : 2*WIDTH working register.
//               multiply: {partial product high half, remaining multiplier bits}
//               divide  : {partial remainder, remaining dividend bits / quotient}
//   i_operand : multiplicand (multiply) or divisor (divide) magnitude.
//   o_acc     : working register after this step.
//   o_qbit    : quotient bit produced by this step (0 in multiply mode).
module frisc_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               i_div,
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_operand,
    output logic [2*WIDTH-1:0] o_acc,
    output logic               o_qbit
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_trial;
    logic [WIDTH:0] w_diff;

    always_comb begin
        o_acc  = '0;
        o_qbit = 1'b0;
        // Multiply: add multiplicand into the high half when the multiplier
        // LSB is set, then shift the whole register right (carry included).
        w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_operand} : '0);
        // Divide: shift the next dividend bit into the remainder and try a subtract.
        // The remainder stays below the divisor, so bit WIDTH of the difference
        // is a reliable borrow flag.
        w_trial = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
        w_diff  = w_trial - {1'b0, i_operand};
        if (i_div) begin
            if (!w_diff[WIDTH]) begin
                o_acc  = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
                o_qbit = 1'b1;
            end else begin
                o_acc  = {w_trial[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/frisc_muldiv.sv
// frisc_muldiv: iterative RV32M multiply/divide unit, one bit per cycle.
//   clk   : clock.
//   rst_n : asynchronous active-low reset.
//   flush : synchronous abort of any in-flight or held operation.
//   bus   : frisc_muldiv_if.slave request/response handshake.
// Accepted ops take WIDTH BUSY cycles; divide-by-zero and signed overflow
// bypass iteration and complete one cycle after accept.
module frisc_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    frisc_muldiv_if.slave  bus
);
    import frisc_pkg::*;

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    muldiv_state_e      r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_resp;
    muldiv_op_e         r_op;
    logic               r_neg;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;

    logic               w_accept;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_div_zero;
    logic               w_ovf;
    logic               w_fast;
    logic [WIDTH-1:0]   w_fast_res;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_final;

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.resp_valid = (r_state == DONE);
    assign bus.resp_data  = r_resp;

    assign w_accept = bus.req_valid && (r_state == IDLE) && !flush;

    // Operand conditioning at accept: magnitudes plus the sign of the result.
    assign w_a_neg = a_signed(bus.req_op) && bus.req_a[WIDTH-1];
    assign w_b_neg = b_signed(bus.req_op) && bus.req_b[WIDTH-1];
    assign w_mag_a = w_a_neg ? -bus.req_a : bus.req_a;
    assign w_mag_b = w_b_neg ? -bus.req_b : bus.req_b;

    // Cases with architecturally fixed results skip the iteration entirely.
    assign w_div_zero = is_div(bus.req_op) && (bus.req_b == '0);
    assign w_ovf      = (bus.req_op inside {OP_DIV, OP_REM}) &&
                        (bus.req_a == MOST_NEG) && (bus.req_b == '1);
    assign w_fast     = w_div_zero || w_ovf;

    always_comb begin
        w_fast_res = '0;
        if (w_div_zero)
            w_fast_res = is_rem(bus.req_op) ? bus.req_a : '1;
        else if (w_ovf)
            w_fast_res = is_rem(bus.req_op) ? '0 : bus.req_a;
    end

    frisc_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_div     (is_div(r_op)),
        .i_acc     (r_acc),
        .i_operand (r_opnd),
        .o_acc     (w_acc_nxt),
        .o_qbit    (w_qbit)
    );

    // Sign fixup on the last step's output; the product is negated at full
    // width so MULH* high halves carry the borrow correctly.
    assign w_prod = r_neg ? -w_acc_nxt : w_acc_nxt;
    assign w_quot = {w_acc_nxt[WIDTH-1:1], w_qbit};
    assign w_rem  = w_acc_nxt[2*WIDTH-1:WIDTH];

    always_comb begin
        w_final = '0;
        case (r_op)
            OP_MUL:                        w_final = w_prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  w_final = w_prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:               w_final = r_neg ? -w_quot : w_quot;
            default:                       w_final = r_neg ? -w_rem : w_rem;
        endcase
    end

    // Sequencer: state, step counter and the held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_resp  <= '0;
        end else if (flush) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (w_fast) begin
                            r_resp  <= w_fast_res;
                            r_state <= DONE;
                        end else begin
                            r_cnt   <= CW'(WIDTH - 1);
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == '0) begin
                        r_resp  <= w_final;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.resp_ready)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Datapath registers: loaded at accept, advanced on every BUSY cycle.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op   <= bus.req_op;
            r_neg  <= is_rem(bus.req_op) ? w_a_neg : (w_a_neg ^ w_b_neg);
            r_acc  <= is_div(bus.req_op) ? {{WIDTH{1'b0}}, w_mag_a} : {{WIDTH{1'b0}}, w_mag_b};
            r_opnd <= is_div(bus.req_op) ? w_mag_b : w_mag_a;
        end else if (r_state == BUSY) begin
            r_acc  <= w_acc_nxt;
        end
    end

endmodule

// File: tb/tb_frisc_muldiv.sv
// tb_frisc_muldiv: self-checking bench for frisc_muldiv (WIDTH=32).
// Directed RV32M cases, backpressure, flush/reset aborts and random ops
// compared against a plain-arithmetic reference model.
module tb_frisc_muldiv;
    import frisc_pkg::*;

    localparam int W = 32;
    localparam logic [31:0] MOST_NEG = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    always #5 clk = ~clk;

    frisc_muldiv_if #(.WIDTH(W)) bus ();

    frisc_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: RV32M semantics from 64-bit two's-complement arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] sa, sb, za, zb, p;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        za = {32'd0, a};
        zb = {32'd0, b};
        p  = '0;
        r  = '0;
        case (op)
            3'd0: begin p = sa * sb; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * zb; r = p[63:32]; end
            3'd3: begin p = za * zb; r = p[63:32]; end
            default: begin
                if (b == 32'd0)
                    r = op[1] ? a : 32'hFFFF_FFFF;
                else if (!op[0] && a == MOST_NEG && b == 32'hFFFF_FFFF)
                    r = op[1] ? 32'd0 : a;
                else case (op)
                    3'd4:    r = 32'($signed(a) / $signed(b));
                    3'd5:    r = a / b;
                    3'd6:    r = 32'($signed(a) % $signed(b));
                    default: r = a % b;
                endcase
            end
        endcase
        return r;
    endfunction

    function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return op[2] && ((b == 32'd0) ||
               (!op[0] && a == MOST_NEG && b == 32'hFFFF_FFFF));
    endfunction

    // Issue one op, check its latency and result, stall the response for
    // 'hold' cycles while offering junk requests, then pop it.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int hold);
        int n;
        logic [31:0] held;
        chk({tag, ":ready"}, 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = muldiv_op_e'(op);
        bus.req_a     = a;
        bus.req_b     = b;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_op    = muldiv_op_e'(3'($urandom));
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
        n = 0;
        while (!bus.resp_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        // Edges after the accept edge until resp_valid: WIDTH iterative, none fast.
        chk({tag, ":lat"}, 64'(n), is_fast(op, a, b) ? 64'd0 : 64'(W));
        chk({tag, ":data"}, 64'(bus.resp_data), 64'(exp));
        held = bus.resp_data;
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            bus.req_op    = muldiv_op_e'(3'($urandom));
            bus.req_a     = $urandom;
            bus.req_b     = $urandom;
            @(posedge clk); #1;
            chk({tag, ":hold_data"}, 64'(bus.resp_data), 64'(held));
            chk({tag, ":hold_vr"}, {62'd0, bus.resp_valid, bus.req_ready}, 64'b10);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        chk({tag, ":pop_vr"}, {62'd0, bus.resp_valid, bus.req_ready}, 64'b01);
    endtask

    // Start a long DIVU and stop right after its ninth BUSY step.
    task automatic start_and_run_9(input string tag);
        chk({tag, ":ready"}, 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_DIVU;
        bus.req_a     = $urandom;
        bus.req_b     = $urandom | 32'd1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int          sel;
        bit          seen;

        rst_n          = 1'b0;
        flush          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_op     = OP_MUL;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b0;
        #12;
        chk("reset_ready", 64'(bus.req_ready), 64'd1);
        chk("reset_valid", 64'(bus.resp_valid), 64'd0);
        chk("reset_data", 64'(bus.resp_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed arithmetic.
        run_op("mul_7_m3",   3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        run_op("mulh_min",   3'd1, MOST_NEG,       MOST_NEG,      32'h4000_0000, 0);
        run_op("mulhu_min",  3'd3, MOST_NEG,       MOST_NEG,      32'h4000_0000, 0);
        run_op("mulhsu",     3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 0);
        run_op("divu",       3'd5, 32'd100,        32'd7,         32'd14,        0);
        run_op("remu",       3'd7, 32'd100,        32'd7,         32'd2,         0);
        run_op("div_neg",    3'd4, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 0);
        run_op("rem_neg",    3'd6, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE, 0);
        run_op("div_by0",    3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 0);
        run_op("remu_by0",   3'd7, 32'd5,          32'd0,         32'd5,         0);
        run_op("div_ovf",    3'd4, MOST_NEG,       32'hFFFF_FFFF, MOST_NEG,      0);
        run_op("rem_ovf",    3'd6, MOST_NEG,       32'hFFFF_FFFF, 32'd0,         0);

        // Backpressure: response held for 10 cycles with requests offered.
        run_op("bp_divu",    3'd5, 32'd1000,       32'd33,        32'd30,        10);
        run_op("bp_fast",    3'd5, 32'd1,          32'd0,         32'hFFFF_FFFF, 3);

        // Flush beats accept in IDLE.
        flush = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op    = OP_MUL;
        @(posedge clk); #1;
        flush = 1'b0;
        bus.req_valid = 1'b0;
        chk("flush_idle_vr", {62'd0, bus.resp_valid, bus.req_ready}, 64'b01);

        // Flush at BUSY step 10, with a competing request offered.
        start_and_run_9("flush_busy");
        flush = 1'b1;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        bus.req_valid = 1'b0;
        chk("flush_busy_vr", {62'd0, bus.resp_valid, bus.req_ready}, 64'b01);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen |= bus.resp_valid;
        end
        chk("flush_no_resp", 64'(seen), 64'd0);
        run_op("post_flush", 3'd5, 32'd9, 32'd3, 32'd3, 0);

        // Flush while a result is held.
        bus.req_valid = 1'b1;
        bus.req_op    = OP_DIV;
        bus.req_a     = 32'd5;
        bus.req_b     = 32'd0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("flush_done_pre", 64'(bus.resp_valid), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_done_vr", {62'd0, bus.resp_valid, bus.req_ready}, 64'b01);

        // Asynchronous reset at BUSY step 10; resp_data still holds 0xFFFFFFFF.
        start_and_run_9("rst_busy");
        rst_n = 1'b0;
        #1;
        chk("rst_busy_vr", {62'd0, bus.resp_valid, bus.req_ready}, 64'b01);
        chk("rst_busy_data", 64'(bus.resp_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst", 3'd5, 32'd9, 32'd3, 32'd3, 0);

        // Random ops against the model, including forced corner operands.
        for (int it = 0; it < 40; it++) begin
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = MOST_NEG; b = 32'hFFFF_FFFF; end
            else if (sel == 2) begin a = a % 1000; b = (b % 50) + 1; end
            else if (sel == 3) b = b | 32'h8000_0000;
            run_op($sformatf("rnd%0d_op%0d", it, op), op, a, b, model(op, a, b),
                   $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
